decoder_acc_requant: RTL and testbench



---
 rtl/decoder_acc_requant.sv | 99 +++++++++
 tb/tb_decoder_acc_requant.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_acc_requant.sv
// Accumulates a tlast-delimited vector of signed products onto a bias, then requantizes
// (arithmetic shift + 16-bit saturation) onto a valid/ready output. Optional ReLU: DECODER_ACC_RELU_EN.
module decoder_acc_requant #(
    parameter int PROD_WIDTH = 24,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [ACC_WIDTH-1:0]  bias,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tvalid,
    output logic                  prod_tready,
    input  logic                  prod_tlast,
    output logic [OUT_WIDTH-1:0]  out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  sat_flag,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    state_t                       state, state_next;
    logic signed [ACC_WIDTH-1:0]  acc, acc_next;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  shifted, activated;
    logic [OUT_WIDTH-1:0]         result;
    logic                         beat, capture, sat_hi, sat_lo;

    assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
    assign beat     = prod_tvalid & prod_tready;
    assign capture  = beat & prod_tlast;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        acc_next   = acc;
        case (state)
            IDLE: if (beat) begin
                acc_next   = $signed(bias) + prod_ext;
                state_next = prod_tlast ? OUT : ACC;
            end
            ACC: if (beat) begin
                acc_next = acc + prod_ext;
                if (prod_tlast) state_next = OUT;
            end
            OUT: if (out_tready) begin
                acc_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prod_tready = (state != OUT);
        out_tvalid  = (state == OUT);
        busy        = (state != IDLE);
    end

    // Requantize the value being written into acc on the tlast edge, not the stale register.
    always_comb begin
        shifted   = acc_next >>> FRAC_SHIFT;
        activated = shifted;
`ifdef DECODER_ACC_RELU_EN
        if (shifted < 0) activated = '0;
`endif
        sat_hi = (activated > OUT_MAX);
        sat_lo = (activated < OUT_MIN);
        if (sat_hi)      result = OUT_WIDTH'(OUT_MAX);
        else if (sat_lo) result = OUT_WIDTH'(OUT_MIN);
        else             result = OUT_WIDTH'(activated);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            out_tdata <= '0;
            sat_flag  <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            if (capture) begin
                out_tdata <= result;
                if (sat_hi || sat_lo) sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decoder_acc_requant.sv
// Directed self-checking bench for decoder_acc_requant; honours DECODER_ACC_RELU_EN when defined.
module tb_decoder_acc_requant;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [31:0] bias;
    logic [23:0] prod_tdata;
    logic        prod_tvalid, prod_tready, prod_tlast;
    logic [15:0] out_tdata;
    logic        out_tvalid, out_tready;
    logic        sat_flag, busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_out  = '0;
    logic        m_sat    = 1'b0;

    decoder_acc_requant dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .bias        (bias),
        .prod_tdata  (prod_tdata),
        .prod_tvalid (prod_tvalid),
        .prod_tready (prod_tready),
        .prod_tlast  (prod_tlast),
        .out_tdata   (out_tdata),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .sat_flag    (sat_flag),
        .busy        (busy)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: wrap to 32 bits, floor-divide by 256, optional ReLU, clamp to int16.
    function automatic logic [15:0] requant(input longint sum, output logic clamped);
        longint s32, q;
        logic [31:0] low;
        low = sum[31:0];
        s32 = longint'($signed(low));
        q   = (s32 >= 0) ? s32 / 256 : -((-s32 + 255) / 256);
        clamped = 1'b0;
`ifdef DECODER_ACC_RELU_EN
        if (q < 0) q = 0;
`endif
        if (q > 32767) begin
            q = 32767;
            clamped = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            clamped = 1'b1;
        end
        return q[15:0];
    endfunction

    // Cycle-by-cycle compare while out of reset.
    always @(negedge ap_clk) begin
        if (ap_rst_n === 1'b1) begin
            check("mon_sat_flag", sat_flag, m_sat);
            if (out_tvalid) begin
                check("mon_out_tdata", out_tdata, exp_out);
                check("mon_tready_low_in_out", prod_tready, 1'b0);
                check("mon_busy_in_out", busy, 1'b1);
            end
        end
    end

    task automatic run_vec(input string name, input logic [31:0] b, input int n,
                           input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] p2,
                           input logic [15:0] lit_out, input logic lit_sat);
        longint sum;
        logic   cl;
        sum = longint'($signed(b));
        for (int i = 0; i < n; i++) begin
            logic [23:0] p;
            p = (i == 0) ? p0 : (i == 1) ? p1 : p2;
            bias        = b;
            prod_tdata  = p;
            prod_tvalid = 1'b1;
            prod_tlast  = (i == n - 1);
            check({name, "_tready"}, prod_tready, 1'b1);
            sum += longint'($signed(p));
            @(posedge ap_clk);
            #1;
        end
        prod_tvalid = 1'b0;
        prod_tlast  = 1'b0;
        exp_out = requant(sum, cl);
        m_sat   = m_sat | cl;
        check({name, "_latency_valid"}, out_tvalid, 1'b1);
        check({name, "_model_data"}, out_tdata, exp_out);
        check({name, "_literal_data"}, out_tdata, lit_out);
        check({name, "_literal_sat"}, sat_flag, lit_sat);
    endtask

    task automatic drain(input string name);
        out_tready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_tready = 1'b0;
        check({name, "_drain_valid"}, out_tvalid, 1'b0);
        check({name, "_drain_busy"}, busy, 1'b0);
        check({name, "_drain_tready"}, prod_tready, 1'b1);
    endtask

    task automatic apply_reset();
        prod_tvalid = 1'b0;
        prod_tlast  = 1'b0;
        ap_rst_n    = 1'b0;
        m_sat       = 1'b0;
        #2;
        check("rst_out_tvalid", out_tvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_tdata", out_tdata, 16'h0);
        check("rst_sat_flag", sat_flag, 1'b0);
        check("rst_prod_tready", prod_tready, 1'b1);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    initial begin
        ap_rst_n    = 1'b1;
        bias        = '0;
        prod_tdata  = '0;
        prod_tvalid = 1'b0;
        prod_tlast  = 1'b0;
        out_tready  = 1'b0;
        #1;
        apply_reset();
        @(posedge ap_clk);
        #1;

        run_vec("three_beat", 32'd0, 3, 24'd256, 24'd512, 24'd768, 16'd6, 1'b0);
        drain("three_beat");

`ifdef DECODER_ACC_RELU_EN
        run_vec("single_neg", 32'hFFFF_FF00, 1, 24'hFFFF00, 24'd0, 24'd0, 16'h0000, 1'b0);
        drain("single_neg");
        run_vec("floor_m1", 32'd0, 1, 24'hFFFFFF, 24'd0, 24'd0, 16'h0000, 1'b0);
`else
        run_vec("single_neg", 32'hFFFF_FF00, 1, 24'hFFFF00, 24'd0, 24'd0, 16'hFFFE, 1'b0);
        drain("single_neg");
        run_vec("floor_m1", 32'd0, 1, 24'hFFFFFF, 24'd0, 24'd0, 16'hFFFF, 1'b0);
`endif
        drain("floor_m1");
        run_vec("floor_255", 32'd0, 1, 24'd255, 24'd0, 24'd0, 16'h0000, 1'b0);
        drain("floor_255");

        // Backpressure: OUT held 5 cycles while upstream keeps a valid beat pending.
        run_vec("bp", 32'h100, 1, 24'h200, 24'd0, 24'd0, 16'd3, 1'b0);
        bias        = 32'd0;
        prod_tdata  = 24'h500;
        prod_tvalid = 1'b1;
        prod_tlast  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge ap_clk);
            #1;
            check("bp_tready_low", prod_tready, 1'b0);
            check("bp_data_stable", out_tdata, 16'd3);
        end
        out_tready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_tready = 1'b0;
        check("bp_release_valid", out_tvalid, 1'b0);
        check("bp_release_tready", prod_tready, 1'b1);
        @(posedge ap_clk);
        #1;
        prod_tvalid = 1'b0;
        prod_tlast  = 1'b0;
        exp_out = 16'd5;
        check("bp_next_accepted", out_tvalid, 1'b1);
        check("bp_next_data", out_tdata, 16'd5);
        drain("bp");

        // Reset mid-vector discards the partial sum.
        bias        = 32'd1000;
        prod_tdata  = 24'd256;
        prod_tvalid = 1'b1;
        prod_tlast  = 1'b0;
        repeat (2) begin
            @(posedge ap_clk);
            #1;
        end
        check("mid_busy_before_reset", busy, 1'b1);
        apply_reset();
        run_vec("after_reset", 32'd0, 1, 24'd256, 24'd0, 24'd0, 16'd1, 1'b0);
        drain("after_reset");

        run_vec("sat_pos", 32'h0080_0000, 1, 24'd0, 24'd0, 24'd0, 16'h7FFF, 1'b1);
        drain("sat_pos");
        apply_reset();
`ifdef DECODER_ACC_RELU_EN
        run_vec("sat_neg", 32'hFF7F_FF00, 1, 24'd0, 24'd0, 24'd0, 16'h0000, 1'b0);
`else
        run_vec("sat_neg", 32'hFF7F_FF00, 1, 24'd0, 24'd0, 24'd0, 16'h8000, 1'b1);
`endif
        drain("sat_neg");

        repeat (2) @(posedge ap_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
